ovl_always_multi_wrapped: RTL and testbench
===========================================

Name: ovl_always_multi_wrapped

Overview:
- Parametrised multi-channel successor to the single-channel OVL "always" checker wrapper.
- Monitors NUM_CH test expressions in parallel, each with its own enable.
- A channel fires only after THRESH consecutive failing cycles.
- Keeps a saturating global fire counter and chains configuration-invalid status to the next fabric checker.

Parameters:
- NUM_CH, 4: number of monitored channels (1..32).
- THRESH, 1: consecutive failing cycles required to fire (1..255). THRESH=1 reproduces single-cycle "always" semantics.
- CNT_W, 8: width of fire_count (2..16).

Ports:
- clk  input  1  checker clock.
- rst  input  1  asynchronous active-low reset.
- enable  input  1  global checker enable.
- ch_enable  input  NUM_CH  per-channel enable mask.
- test_expr  input  NUM_CH  per-channel expression that must always be 1.
- prevConfigInvalid  input  1  upstream checker configuration invalid.
- clear  input  1  synchronous clear of run counters, fire_count and sticky flags.
- out  output  NUM_CH  per-channel fire, same-cycle (combinational).
- any_fire  output  1  OR-reduction of out.
- fire_count  output  CNT_W  registered count of cycles with any_fire, saturating.
- fired_sticky  output  NUM_CH  registered sticky fire flags (optional feature).
- configInvalid  output  1  downstream configuration-invalid chain.

Behaviour:
- Reset: rst=0 asynchronously clears run[i], fire_count and fired_sticky to 0. While rst=0, out, any_fire and configInvalid are forced to 0.
- Illegal parameters: param_bad = (THRESH==0) || (THRESH>255).
- configInvalid = rst && (prevConfigInvalid || param_bad), combinational.
- fail[i] = rst & enable & ch_enable[i] & ~prevConfigInvalid & ~param_bad & ~test_expr[i].
- run[i]:
  - Register, width RW = clog2(THRESH+1).
  - Next value = clear ? 0 : fail[i] ? min(run[i]+1, THRESH) : 0.
  - Saturates at THRESH and never wraps.
- out[i] = fail[i] && (run[i] >= THRESH-1).
  - THRESH=1: out[i]=fail[i] in the same cycle.
  - THRESH=3: out[i] rises in the 3rd consecutive failing cycle and stays high while failing continues.
  - Any passing or disabled cycle drops out[i] in that same cycle and zeroes run[i] at the next edge.
- Clear vs fail: clear has no effect on out in the current cycle. It zeroes run[i] at the next edge, so a continuing failure must re-accumulate THRESH cycles.
- fire_count:
  - Next value = clear ? 0 : (any_fire && fire_count != all-ones) ? fire_count+1 : fire_count.
  - Saturates at 2^CNT_W-1. clear wins over a simultaneous fire.
- Enable drop: enable, ch_enable[i] or prevConfigInvalid dropping mid-run counts as a non-fail cycle and resets run[i].
- Reset mid-run discards all partial runs.
- No internal state machine beyond the counters. All registers update on posedge clk only.

Optional Feature:
- Macro: OVL_ALWAYS_MULTI_STICKY_EN.
- Defined:
  - fired_sticky[i] sets at the clock edge after any cycle with out[i]=1.
  - Holds until clear=1 or rst=0. Clear wins over a simultaneous set.
- Undefined: fired_sticky is tied to 0 and no sticky flops are instantiated. All other behaviour is identical.

Test Plan:
- NUM_CH=4, THRESH=1; rst 0->1, enable=1, ch_enable=4'b1111, test_expr=4'b1011 -> same cycle out=4'b0100, any_fire=1; fire_count=1 at next edge.
- THRESH=3; ch0 test_expr=0 for 5 cycles -> out[0] = 0,0,1,1,1; then test_expr=1 for 1 cycle and 0 again -> out[0] low for the next 2 failing cycles, high on the 3rd.
- THRESH=1, CNT_W=2; failure held 6 cycles -> fire_count 1,2,3,3,3; assert clear with failure still present -> fire_count=0 next edge, out still 1 in the clear cycle.
- prevConfigInvalid=1 with test_expr=0 -> out=0, configInvalid=1; rst=0 mid-run -> all outputs 0 immediately, asynchronously, and fire_count=0.
- OVL_ALWAYS_MULTI_STICKY_EN defined: ch2 fails one cycle -> fired_sticky[2]=1 from next edge, held after failure ends; clear -> 0 next edge. Undefined: fired_sticky stays 0.

Source files
------------

// File: rtl/ovl_always_multi_wrapped.sv
// Multi-channel "always" checker: each channel fires after THRESH consecutive failing cycles.
// Define OVL_ALWAYS_MULTI_STICKY_EN to build the per-channel sticky fire flags.
module ovl_always_multi_wrapped #(
    parameter int NUM_CH = 4,
    parameter int THRESH = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] test_expr,
    input  logic              prevConfigInvalid,
    input  logic              clear,
    output logic [NUM_CH-1:0] out,
    output logic              any_fire,
    output logic [CNT_W-1:0]  fire_count,
    output logic [NUM_CH-1:0] fired_sticky,
    output logic              configInvalid
);

    localparam logic PARAM_BAD = (THRESH == 0) || (THRESH > 255);
    // A zero THRESH is illegal, but the run counter still needs a legal width.
    localparam int RW = (THRESH < 1) ? 1 : $clog2(THRESH + 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'((THRESH < 1) ? 0 : THRESH);
    localparam logic [RW-1:0] RUN_FIRE = RW'((THRESH < 1) ? 0 : THRESH - 1);

    logic              checking;
    logic [NUM_CH-1:0] fail;
    logic [NUM_CH-1:0] at_thresh;
    logic [NUM_CH-1:0] out_w;
    logic [RW-1:0]     run_q [NUM_CH];
    logic [RW-1:0]     run_d [NUM_CH];
    logic [CNT_W-1:0]  fire_count_q;
    logic [CNT_W-1:0]  fire_count_d;

    generate
        if (THRESH <= 1) begin : g_single
            assign at_thresh = '1;
        end else begin : g_multi
            for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
                assign at_thresh[g] = (run_q[g] >= RUN_FIRE);
            end
        end
    endgenerate

    always_comb begin
        checking = rst & enable & ~prevConfigInvalid & ~PARAM_BAD;
        fail     = '0;
        out_w    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fail[i]  = checking & ch_enable[i] & ~test_expr[i];
            out_w[i] = fail[i] & at_thresh[i];
            run_d[i] = '0;
            if (!clear && fail[i]) begin
                run_d[i] = (run_q[i] == RUN_MAX) ? run_q[i] : run_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        fire_count_d = fire_count_q;
        if (clear) begin
            fire_count_d = '0;
        end else if ((|out_w) && (fire_count_q != {CNT_W{1'b1}})) begin
            fire_count_d = fire_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                run_q[i] <= '0;
            end
            fire_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                run_q[i] <= run_d[i];
            end
            fire_count_q <= fire_count_d;
        end
    end

`ifdef OVL_ALWAYS_MULTI_STICKY_EN
    logic [NUM_CH-1:0] sticky_q;
    logic [NUM_CH-1:0] sticky_d;

    always_comb begin
        sticky_d = clear ? '0 : (sticky_q | out_w);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign fired_sticky = sticky_q;
`else
    assign fired_sticky = '0;
`endif

    assign out           = out_w;
    assign any_fire      = |out_w;
    assign fire_count    = fire_count_q;
    assign configInvalid = rst & (prevConfigInvalid | PARAM_BAD);

endmodule

// File: tb/tb_ovl_always_multi_wrapped.sv
// Directed bench for ovl_always_multi_wrapped: THRESH=1/CNT_W=2, THRESH=3 and an
// illegal THRESH=0 instance share one stimulus stream.
module tb_ovl_always_multi_wrapped;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] ch_enable;
  logic [3:0] test_expr;
  logic       prev_ci;
  logic       clear;

  logic [3:0] out1, out3, outb;
  logic       af1, af3, afb;
  logic [1:0] fc1;
  logic [7:0] fc3, fcb;
  logic [3:0] st1, st3, stb;
  logic       ci1, ci3, cib;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ovl_always_multi_wrapped #(.NUM_CH(4), .THRESH(1), .CNT_W(2)) u_t1 (
    .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable),
    .test_expr(test_expr), .prevConfigInvalid(prev_ci), .clear(clear),
    .out(out1), .any_fire(af1), .fire_count(fc1), .fired_sticky(st1),
    .configInvalid(ci1)
  );

  ovl_always_multi_wrapped #(.NUM_CH(4), .THRESH(3), .CNT_W(8)) u_t3 (
    .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable),
    .test_expr(test_expr), .prevConfigInvalid(prev_ci), .clear(clear),
    .out(out3), .any_fire(af3), .fire_count(fc3), .fired_sticky(st3),
    .configInvalid(ci3)
  );

  ovl_always_multi_wrapped #(.NUM_CH(4), .THRESH(0), .CNT_W(8)) u_bad (
    .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable),
    .test_expr(test_expr), .prevConfigInvalid(prev_ci), .clear(clear),
    .out(outb), .any_fire(afb), .fire_count(fcb), .fired_sticky(stb),
    .configInvalid(cib)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] exp_run5;
  logic [2:0] exp_run3;
  logic [1:0] exp_sat [5];
  logic [3:0] exp_sticky;

  initial begin
    exp_run5 = 5'b11100;
    exp_run3 = 3'b100;
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
`ifdef OVL_ALWAYS_MULTI_STICKY_EN
    exp_sticky = 4'b0100;
`else
    exp_sticky = 4'b0000;
`endif

    rst = 1'b0; enable = 1'b1; ch_enable = 4'b1111; test_expr = 4'b1011;
    prev_ci = 1'b0; clear = 1'b0;
    tick(); tick();
    #2;
    check("rst_out", 32'(out1), 32'h0);
    check("rst_any_fire", 32'(af1), 32'h0);
    check("rst_fire_count", 32'(fc1), 32'h0);
    check("rst_config_invalid", 32'(ci1), 32'h0);
    check("rst_bad_config_invalid", 32'(cib), 32'h0);
    check("rst_sticky", 32'(st1), 32'h0);

    // Release reset with ch2 failing: THRESH=1 fires in the same cycle.
    rst = 1'b1;
    #1;
    check("t1_out", 32'(out1), 32'h4);
    check("t1_any_fire", 32'(af1), 32'h1);
    check("t3_out_first", 32'(out3), 32'h0);
    check("t1_config_invalid", 32'(ci1), 32'h0);
    check("bad_config_invalid", 32'(cib), 32'h1);
    check("bad_out", 32'(outb), 32'h0);
    tick();
    check("t1_fire_count", 32'(fc1), 32'h1);
    check("sticky_set", 32'(st1), 32'(exp_sticky));
    test_expr = 4'b1111;
    tick();
    check("sticky_hold", 32'(st1), 32'(exp_sticky));
    check("t1_fire_count_hold", 32'(fc1), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("sticky_clear", 32'(st1), 32'h0);
    check("clear_fire_count", 32'(fc1), 32'h0);

    // THRESH=3 run: out rises on the third consecutive failing cycle.
    test_expr = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      #1 check("t3_run5", 32'(out3[0]), 32'(exp_run5[k]));
      tick();
    end
    test_expr = 4'b1111;
    #1 check("t3_pass_gap", 32'(out3), 32'h0);
    tick();
    test_expr = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      #1 check("t3_rerun", 32'(out3[0]), 32'(exp_run3[k]));
      tick();
    end

    // Enable drop mid-run restarts accumulation.
    enable = 1'b0;
    #1 check("t3_enable_drop", 32'(out3), 32'h0);
    check("t3_enable_drop_any", 32'(af3), 32'h0);
    tick();
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check("t3_after_enable", 32'(out3[0]), 32'(exp_run3[k]));
      tick();
    end

    // Clear leaves the current cycle's fire alone but restarts the run.
    clear = 1'b1;
    #1 check("t3_clear_cycle", 32'(out3[0]), 32'h1);
    tick();
    clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("t3_after_clear", 32'(out3[0]), 32'(exp_run3[k]));
      tick();
    end
    test_expr = 4'b1111;
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // CNT_W=2 saturation, then clear while still failing.
    test_expr = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t1_saturate", 32'(fc1), 32'(exp_sat[k]));
    end
    clear = 1'b1;
    #1 check("t1_clear_cycle_out", 32'(out1[0]), 32'h1);
    tick();
    clear = 1'b0;
    check("t1_clear_wins", 32'(fc1), 32'h0);

    // Upstream configuration invalid suppresses all firing.
    prev_ci = 1'b1;
    test_expr = 4'b0000;
    #1 check("prev_ci_out1", 32'(out1), 32'h0);
    check("prev_ci_out3", 32'(out3), 32'h0);
    check("prev_ci_any", 32'(af1), 32'h0);
    check("prev_ci_config_invalid", 32'(ci1), 32'h1);
    tick();
    check("prev_ci_no_count", 32'(fc1), 32'h0);
    prev_ci = 1'b0;
    tick(); tick();
    check("resume_count", 32'(fc1), 32'h2);
    #1 check("t3_all_fire", 32'(out3), 32'hf);

    // Asynchronous reset mid-run.
    rst = 1'b0;
    prev_ci = 1'b1;
    #1;
    check("async_rst_out1", 32'(out1), 32'h0);
    check("async_rst_out3", 32'(out3), 32'h0);
    check("async_rst_any", 32'(af1), 32'h0);
    check("async_rst_count", 32'(fc1), 32'h0);
    check("async_rst_config_invalid", 32'(ci1), 32'h0);
    check("async_rst_bad_config_invalid", 32'(cib), 32'h0);
    tick();
    rst = 1'b1;
    prev_ci = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("t3_after_reset", 32'(out3[0]), 32'(exp_run3[k]));
      tick();
    end
    test_expr = 4'b1111;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
